state_pack_poly_tobytes_unmask: RTL
===================================

// Module: state_pack_poly_tobytes_unmask
// PURPOSE
//  Inverse of the masked unpack stage. Takes a K-polynomial vector as two arithmetic shares mod q, 8 coefficients per beat.
//  Recombines each coefficient as (s1+s2) mod q and packs it to 12 bits, Kyber poly_tobytes order.
//  Assembles the full KYBER_POLYBYTES*KYBER_K byte string for the encode/serialise path.
// PARAMETERS
//  KYBER_K          2     polynomials in the vector
//  KYBER_N          256   coefficients per polynomial
//  KYBER_Q          3329  modulus
//  KYBER_POLYBYTES  384   packed bytes per polynomial
//  OPOLY_SZ         8*KYBER_POLYBYTES*KYBER_K (6144)  packed output width
//  IPOLY_SZ         128   share beat width (8 x 16-bit coefficients)
//  NCHUNK           KYBER_K*KYBER_N/8 (64)  beats per vector
// PORTS
//  clk            in   1         clock
//  resetn         in   1         async active-low reset
//  enable         in   1         start pulse; sampled in IDLE only
//  in_valid       in   1         beat valid
//  i_poly_s1      in   IPOLY_SZ  share 1, coeff j at [16j+15:16j], value in [0,q)
//  i_poly_s2      in   IPOLY_SZ  share 2, same layout
//  in_ready       out  1         block accepts a beat this cycle
//  o_bytes        out  OPOLY_SZ  packed output; beat n at [96n+95:96n], byte 0 at [7:0]
//  Function_Done  out  1         one-cycle pulse when all NCHUNK beats are packed
//  o_err          out  1         sticky share-range error (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: in_ready=0, Function_Done=0, o_bytes=0, o_err=0, n=0, state=IDLE.
//  FSM states: IDLE, RECV, PACK, DONE.
//   IDLE: enable=1 -> RECV; o_err cleared; n=0. Otherwise stay.
//   RECV: in_ready=1 (registered, set on entry). in_valid=1 -> latch the 8 recombined sums into sum_r -> PACK, in_ready=0.
//         in_valid=0 -> stay in RECV.
//   PACK: write {c7..c0} (12 bits each, c0 in LSBs) into o_bytes[96n+95:96n].
//         If n==NCHUNK-1 -> DONE with n=0; else n++ -> RECV.
//   DONE: Function_Done=1 for exactly this cycle -> IDLE.
//  Throughput is 1 beat per 2 cycles. A full vector takes >=2*NCHUNK+2 cycles after enable.
//  Arithmetic per coeff: t = s1+s2 (13 bits); c = (t>=Q) ? t-Q : t; c[11:0] packed.
//   s1=s2=0 -> 0. s1+s2==Q -> 0. Max t=2Q-2 -> Q-2.
//  Byte order matches Kyber: bytes (3i, 3i+1, 3i+2) = c[2i][7:0], {c[2i+1][3:0], c[2i][11:8]}, c[2i+1][11:4].
//  o_bytes is not cleared on enable. Every slice is overwritten during a run, and o_bytes holds after DONE.
//  enable while not IDLE is ignored. in_valid outside RECV is ignored (no beat consumed).
//  Beat handshake: a beat transfers only when in_valid && in_ready in the same cycle.
//  Async reset mid-run aborts immediately to reset values. A partial o_bytes is discarded (zeroed).
//  Shares are consumed combinationally and only sum_r is stored. Unmasked data never leaves via any port except o_bytes.
// CONFIGURATION
//  Macro STATE_PACK_RANGECHK_EN.
//   Defined: in RECV on a transferred beat, o_err is set if any s1 or s2 coefficient >= Q.
//    o_err is sticky until the next IDLE->RECV. Processing continues and the sum still uses the formula above.
//   Undefined: range comparators are not built; o_err is tied to 0.
// STRUCTURE
//  Shared package (kyber_pkg): KYBER_Q, KYBER_N, KYBER_K, KYBER_POLYBYTES, COEFF_SZ=16, PACKED_COEFF_SZ=12, NCHUNK, FSM state encoding.
//  Sub-module state_pack_unmask_coeff: combinational (s1,s2)->12-bit c, plus an optional range flag. Instantiated 8x in a generate loop.
//  Top: FSM, beat counter n (6 bits), sum_r register, o_bytes slice write.
// TESTING
//  T1 all-zero shares, 64 beats -> o_bytes==0; Function_Done pulses once; cycle count == 2*64+2 from enable.
//  T2 beat0 coeffs s1=1..8, s2=0 -> o_bytes[95:0] bytes = 01 20 00 03 40 00 05 60 00 07 80 00.
//  T3 wrap: s1=3328, s2=1 -> c=0; s1=1000, s2=2000 -> c=0xBB8; s1=s2=3328 -> c=3327.
//  T4 in_valid toggled randomly with backpressure -> result equals the golden poly_tobytes of (s1+s2) mod q; no beat lost or duplicated.
//  T5 resetn low at beat 30 -> all outputs 0; new enable -> a clean full run matches the golden model.
//  T6 (macro on) beat 5 with s2 coeff=3329 -> o_err=1 and held through DONE; cleared at next enable. (macro off) o_err stays 0.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and FSM encoding for the masked pack/unpack slice.
package kyber_pkg;

  localparam int unsigned KYBER_K         = 2;
  localparam int unsigned KYBER_N         = 256;
  localparam int unsigned KYBER_Q         = 3329;
  localparam int unsigned KYBER_POLYBYTES = 384;
  localparam int unsigned COEFF_SZ        = 16;
  localparam int unsigned PACKED_COEFF_SZ = 12;
  localparam int unsigned NCOEFF_BEAT     = 8;
  localparam int unsigned IPOLY_SZ        = NCOEFF_BEAT * COEFF_SZ;
  localparam int unsigned OPOLY_SZ        = 8 * KYBER_POLYBYTES * KYBER_K;
  localparam int unsigned NCHUNK          = KYBER_K * KYBER_N / NCOEFF_BEAT;
  localparam int unsigned NCHUNK_W        = $clog2(NCHUNK);
  localparam int unsigned BEAT_W          = NCOEFF_BEAT * PACKED_COEFF_SZ;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRecv = 2'd1,
    StPack = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/state_pack_unmask_coeff.sv
// Recombines one coefficient from two arithmetic shares mod q and truncates it to 12 bits.
// Range flag exists only when STATE_PACK_RANGECHK_EN is defined.
module state_pack_unmask_coeff
  import kyber_pkg::*;
(
  input  logic [COEFF_SZ-1:0]        s1_i,
  input  logic [COEFF_SZ-1:0]        s2_i,
  output logic [PACKED_COEFF_SZ-1:0] c_o
`ifdef STATE_PACK_RANGECHK_EN
  ,
  output logic                       range_err_o
`endif
);

  logic [12:0] t;

  assign t   = 13'(s1_i + s2_i);
  assign c_o = PACKED_COEFF_SZ'((t >= 13'(KYBER_Q)) ? t - 13'(KYBER_Q) : t);

`ifdef STATE_PACK_RANGECHK_EN
  assign range_err_o = (s1_i >= COEFF_SZ'(KYBER_Q)) || (s2_i >= COEFF_SZ'(KYBER_Q));
`endif

endmodule

// File: rtl/state_pack_poly_tobytes_unmask.sv
// Unmasks a K-polynomial share vector beat by beat and packs it in Kyber poly_tobytes order.
// Optional share range check is built when STATE_PACK_RANGECHK_EN is defined.
module state_pack_poly_tobytes_unmask
  import kyber_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [IPOLY_SZ-1:0] i_poly_s1,
  input  logic [IPOLY_SZ-1:0] i_poly_s2,
  output logic                in_ready,
  output logic [OPOLY_SZ-1:0] o_bytes,
  output logic                Function_Done,
  output logic                o_err
);

  state_e              state_q, state_d;
  logic [NCHUNK_W-1:0] n_q, n_d;
  logic                rdy_q, rdy_d;
  logic [BEAT_W-1:0]   sum_q, sum_d, sum_c;
  logic [BEAT_W-1:0]   bytes_q [NCHUNK];
  logic                pack_we;
  logic                beat_xfer;

  assign beat_xfer = (state_q == StRecv) && in_valid && rdy_q;

`ifdef STATE_PACK_RANGECHK_EN
  logic [NCOEFF_BEAT-1:0] range_err;
`endif

  for (genvar g = 0; g < NCOEFF_BEAT; g++) begin : g_coeff
    state_pack_unmask_coeff u_coeff (
      .s1_i       (i_poly_s1[g*COEFF_SZ +: COEFF_SZ]),
      .s2_i       (i_poly_s2[g*COEFF_SZ +: COEFF_SZ]),
      .c_o        (sum_c[g*PACKED_COEFF_SZ +: PACKED_COEFF_SZ])
`ifdef STATE_PACK_RANGECHK_EN
      ,
      .range_err_o(range_err[g])
`endif
    );
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rdy_d   = rdy_q;
    sum_d   = sum_q;
    pack_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRecv;
          rdy_d   = 1'b1;
          n_d     = '0;
        end
      end
      StRecv: begin
        if (beat_xfer) begin
          sum_d   = sum_c;
          rdy_d   = 1'b0;
          state_d = StPack;
        end
      end
      StPack: begin
        pack_we = 1'b1;
        if (n_q == NCHUNK_W'(NCHUNK - 1)) begin
          n_d     = '0;
          state_d = StDone;
        end else begin
          n_d     = n_q + NCHUNK_W'(1);
          rdy_d   = 1'b1;
          state_d = StRecv;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      n_q     <= '0;
      rdy_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rdy_q   <= rdy_d;
      sum_q   <= sum_d;
    end
  end

  // A reset mid-run must not leave a partially unmasked vector visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCHUNK; i++) bytes_q[i] <= '0;
    end else if (pack_we) begin
      bytes_q[n_q] <= sum_q;
    end
  end

  for (genvar g = 0; g < NCHUNK; g++) begin : g_out
    assign o_bytes[g*BEAT_W +: BEAT_W] = bytes_q[g];
  end

  assign in_ready      = rdy_q;
  assign Function_Done = (state_q == StDone);

`ifdef STATE_PACK_RANGECHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && enable) begin
      err_q <= 1'b0;
    end else if (beat_xfer && |range_err) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
